// File: rtl/arr_pkg.sv
// Shared types and saturation helper for the array controller's input and output paths.
package arr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } arr_state_e;

    localparam int SAT_MAX  = 127;
    localparam int SAT_MIN  = -128;
    localparam int ACCW_DEF = 16;

    // Clamp a signed value into int8 range, returned as two's complement.
    function automatic logic [7:0] sat8(input int v);
        logic [7:0] r;
        if (v > SAT_MAX)
            r = 8'(SAT_MAX);
        else if (v < SAT_MIN)
            r = 8'(SAT_MIN);
        else
            r = v[7:0];
        return r;
    endfunction

endpackage

// File: rtl/arr_row_fifo.sv
// Row FIFO between the array's bottom edge and the serializer hold register.
module arr_row_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    // The extra wrap bit separates full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop && !empty)
                rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full && !flush)
            mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/arr_out_drain.sv
// Drains result rows from the array, requantizes each column to int8 and
// streams the bytes to the host. Handshakes: a transfer happens on a clock
// edge where valid and ready are both high; valid never depends on ready.
module arr_out_drain
    import arr_pkg::*;
#(
    parameter int COLS  = 16,
    parameter int ACCW  = ACCW_DEF,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 enable,
    input  logic                 start,
    input  logic [3:0]           shift,
    input  logic [15:0]          total_rows,
    input  logic                 res_valid,
    input  logic [COLS*ACCW-1:0] res_data,
    output logic                 res_ready,
    output logic [7:0]           data_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 done,
    output logic                 overflow,
    output arr_state_e           dbg_state
);

    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW = COLS * ACCW;

    arr_state_e       state;
    logic [RW-1:0]    hold_row;
    logic             hold_valid;
    logic [CW-1:0]    col_idx;
    logic [15:0]      rows_in;
    logic [15:0]      rows_out;
    logic [3:0]       shift_r;
    logic [15:0]      total_r;

    logic [RW-1:0]    fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             hs;
    logic             last_col;
    logic             restart;

    function automatic logic [ACCW-1:0] col_of(input logic [RW-1:0] row,
                                               input logic [CW-1:0] idx);
        return row[idx*ACCW +: ACCW];
    endfunction

    // Floor shift on the signed accumulator, then clamp to int8.
    function automatic logic [7:0] requant(input logic [ACCW-1:0] v,
                                           input logic [3:0] sh);
        logic signed [ACCW-1:0] s;
        s = $signed(v) >>> sh;
        return sat8(int'(s));
    endfunction

    assign restart   = enable & start;
    assign res_ready = enable & (state == ST_RUN) & !fifo_full & (rows_in < total_r);
    assign out_valid = hold_valid & enable;
    assign hs        = out_valid & out_ready;
    assign last_col  = (col_idx == CW'(COLS-1));
    assign push      = res_valid & res_ready;
    // Refill hold as soon as it is empty or its final byte leaves this cycle.
    assign pop       = enable & !fifo_empty & (!hold_valid | (hs & last_col));
    assign done      = (state == ST_DONE);
    assign dbg_state = state;

    arr_row_fifo #(
        .W     (RW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (push),
        .pop   (pop),
        .flush (restart),
        .wdata (res_data),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            hold_row   <= '0;
            hold_valid <= 1'b0;
            col_idx    <= '0;
            rows_in    <= '0;
            rows_out   <= '0;
            shift_r    <= '0;
            total_r    <= '0;
            data_out   <= '0;
            overflow   <= 1'b0;
        end else if (enable) begin
            if (start) begin
                shift_r    <= shift;
                total_r    <= total_rows;
                rows_in    <= '0;
                rows_out   <= '0;
                col_idx    <= '0;
                hold_valid <= 1'b0;
                overflow   <= 1'b0;
                data_out   <= '0;
                state      <= (total_rows == 16'd0) ? ST_DONE : ST_RUN;
            end else begin
                if (push)
                    rows_in <= rows_in + 16'd1;
                if (res_valid && !res_ready && state == ST_RUN)
                    overflow <= 1'b1;
                if (hs && last_col)
                    rows_out <= rows_out + 16'd1;

                if (pop) begin
                    hold_row   <= fifo_rdata;
                    hold_valid <= 1'b1;
                    col_idx    <= '0;
                    data_out   <= requant(col_of(fifo_rdata, '0), shift_r);
                end else if (hs) begin
                    if (last_col) begin
                        hold_valid <= 1'b0;
                    end else begin
                        col_idx  <= col_idx + CW'(1);
                        data_out <= requant(col_of(hold_row, col_idx + CW'(1)), shift_r);
                    end
                end

                if (state == ST_RUN && hs && last_col && (rows_out + 16'd1) == total_r)
                    state <= ST_DONE;
            end
        end
    end

endmodule

// File: tb/tb_arr_out_drain.sv
// Directed bench for arr_out_drain with a byte-stream scoreboard.
module tb_arr_out_drain;

    localparam int COLS  = 4;
    localparam int ACCW  = 16;
    localparam int DEPTH = 2;
    localparam int W     = COLS * ACCW;

    logic                clk = 1'b0;
    logic                rstn = 1'b0;
    logic                enable = 1'b0;
    logic                start = 1'b0;
    logic [3:0]          shift = '0;
    logic [15:0]         total_rows = '0;
    logic                res_valid = 1'b0;
    logic [W-1:0]        res_data = '0;
    logic                res_ready;
    logic [7:0]          data_out;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic                done;
    logic                overflow;
    arr_pkg::arr_state_e dbg_state;

    int         checks = 0;
    int         failures = 0;
    int         bytes_seen = 0;
    int         cur_shift = 0;
    bit         mon_en = 1'b0;
    logic [7:0] exp_q[$];

    arr_out_drain #(.COLS(COLS), .ACCW(ACCW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .enable     (enable),
        .start      (start),
        .shift      (shift),
        .total_rows (total_rows),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_ready  (res_ready),
        .data_out   (data_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .done       (done),
        .overflow   (overflow),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s act=%0d exp=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Floor division by 2^sh, then clamp to int8.
    function automatic logic [7:0] model_byte(input int v, input int sh);
        int d;
        int q;
        d = 1 << sh;
        if (v >= 0)
            q = v / d;
        else
            q = -((-v + d - 1) / d);
        if (q > 127)
            q = 127;
        if (q < -128)
            q = -128;
        return q[7:0];
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int sh, input int tr);
        exp_q.delete();
        cur_shift  = sh;
        shift      = 4'(sh);
        total_rows = 16'(tr);
        start      = 1'b1;
        tick(1);
        start      = 1'b0;
    endtask

    task automatic send_row(input int v0, input int v1, input int v2, input int v3,
                            input bit acc);
        int vals[4];
        vals = '{v0, v1, v2, v3};
        for (int c = 0; c < COLS; c++)
            res_data[c*ACCW +: ACCW] = 16'(vals[c]);
        res_valid = 1'b1;
        check("res_ready", int'(res_ready), int'(acc));
        if (acc)
            for (int c = 0; c < COLS; c++)
                exp_q.push_back(model_byte(vals[c], cur_shift));
        tick(1);
        res_valid = 1'b0;
    endtask

    task automatic wait_bytes(input int target);
        int t;
        t = 0;
        while (bytes_seen < target && t < 200) begin
            tick(1);
            t++;
        end
        check("drain_bytes", bytes_seen, target);
    endtask

    // Scoreboard: any valid byte must be the oldest expected byte.
    always @(negedge clk) begin
        if (mon_en && rstn && out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_byte act=%02h exp=none t=%0t", data_out, $time);
            end else begin
                check("stream_byte", int'(data_out), int'(exp_q[0]));
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    bytes_seen++;
                end
            end
        end
    end

    initial begin
        // Reset values
        #2;
        check("rst_res_ready", int'(res_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_data_out", int'(data_out), 0);
        check("rst_done", int'(done), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_state", int'(dbg_state), int'(arr_pkg::ST_IDLE));
        tick(2);
        rstn   = 1'b1;
        enable = 1'b1;
        tick(1);
        mon_en = 1'b1;

        // Basic row, shift 0, latency and saturation
        do_start(0, 1);
        check("run_state", int'(dbg_state), int'(arr_pkg::ST_RUN));
        out_ready = 1'b1;
        send_row(5, -3, 200, -200, 1'b1);
        check("lat_not_yet", int'(out_valid), 0);
        tick(1);
        check("lat_valid", int'(out_valid), 1);
        check("b0_s0", int'(data_out), 8'h05);
        tick(1);
        check("b1_s0", int'(data_out), 8'hFD);
        tick(1);
        check("b2_s0", int'(data_out), 8'h7F);
        tick(1);
        check("b3_s0", int'(data_out), 8'h80);
        check("done_before_last", int'(done), 0);
        tick(1);
        check("done_after_last", int'(done), 1);
        check("valid_after_last", int'(out_valid), 0);

        // Shift 4 with an enable-low freeze in the middle
        do_start(4, 1);
        check("restart_done", int'(done), 0);
        send_row(291, -1, -17, 32767, 1'b1);
        tick(1);
        check("b0_s4", int'(data_out), 8'h12);
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("en_low_valid", int'(out_valid), 0);
            check("en_low_ready", int'(res_ready), 0);
        end
        enable = 1'b1;
        #1;
        check("en_resume_valid", int'(out_valid), 1);
        check("en_resume_byte", int'(data_out), 8'h12);
        tick(1);
        check("b1_s4", int'(data_out), 8'hFF);
        tick(1);
        check("b2_s4", int'(data_out), 8'hFE);
        tick(1);
        check("b3_s4", int'(data_out), 8'h7F);
        tick(1);
        check("done_s4", int'(done), 1);

        // Backpressure after byte 1
        do_start(0, 1);
        send_row(10, 20, 30, 40, 1'b1);
        tick(1);
        check("bp_b0", int'(data_out), 8'h0A);
        tick(1);
        check("bp_b1", int'(data_out), 8'h14);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("bp_hold_valid", int'(out_valid), 1);
            check("bp_hold_byte", int'(data_out), 8'h14);
        end
        out_ready = 1'b1;
        tick(1);
        check("bp_b2", int'(data_out), 8'h1E);
        tick(1);
        check("bp_b3", int'(data_out), 8'h28);
        tick(1);
        check("bp_done", int'(done), 1);
        check("bp_queue_empty", exp_q.size(), 0);

        // Four back-to-back rows into a two-deep FIFO, host stalled
        do_start(0, 4);
        out_ready = 1'b0;
        send_row(1, 2, 3, 4, 1'b1);
        send_row(11, 12, 13, 14, 1'b1);
        send_row(21, 22, 23, 24, 1'b1);
        send_row(31, 32, 33, 34, 1'b0);
        check("ovf_set", int'(overflow), 1);
        out_ready = 1'b1;
        wait_bytes(bytes_seen + 12);
        tick(5);
        check("ovf_no_done", int'(done), 0);
        check("ovf_sticky", int'(overflow), 1);
        check("ovf_queue_empty", exp_q.size(), 0);

        // Zero-row job, then a restart
        do_start(0, 0);
        check("zero_done", int'(done), 1);
        check("zero_res_ready", int'(res_ready), 0);
        check("zero_ovf_clear", int'(overflow), 0);
        res_valid = 1'b1;
        tick(1);
        res_valid = 1'b0;
        check("zero_ignore_ovf", int'(overflow), 0);
        do_start(0, 2);
        check("re_state", int'(dbg_state), int'(arr_pkg::ST_RUN));
        check("re_done", int'(done), 0);
        check("re_ovf", int'(overflow), 0);
        check("re_res_ready", int'(res_ready), 1);

        // Asynchronous reset in the middle of a row
        send_row(1, 2, 3, 4, 1'b1);
        tick(1);
        check("mid_b0", int'(data_out), 8'h01);
        tick(1);
        check("mid_b1", int'(data_out), 8'h02);
        mon_en = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        check("arst_valid", int'(out_valid), 0);
        check("arst_done", int'(done), 0);
        check("arst_res_ready", int'(res_ready), 0);
        check("arst_state", int'(dbg_state), int'(arr_pkg::ST_IDLE));
        exp_q.delete();
        tick(2);
        rstn = 1'b1;
        mon_en = 1'b1;
        res_valid = 1'b1;
        tick(1);
        res_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            check("post_rst_valid", int'(out_valid), 0);
        end
        check("post_rst_ovf", int'(overflow), 0);
        check("post_rst_state", int'(dbg_state), int'(arr_pkg::ST_IDLE));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
